// File: rtl/axi_pkg.sv
// Shared AXI3 single-beat channel types and bridge FSM encoding for the sram-like bridge.
// Optional build macro used by the bridge: BRIDGE_WR_EARLY_ACK_EN.
package axi_pkg;

  localparam int unsigned AXI_ID_W = 4;
  localparam logic [1:0]  BURST_INCR = 2'b01;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [3:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } axi_ar_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [3:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } axi_aw_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         data;
    logic [1:0]          resp;
    logic                last;
  } axi_r_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         data;
    logic [3:0]          strb;
    logic                last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_AR  = 3'd1,
    ST_RD_R   = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_B   = 3'd4
  } bridge_state_t;

endpackage

// File: rtl/sramlike_axi_bridge_if.sv
// Bus bundles for the bridge: sram-like requester side and AXI3 master side.
// Handshake rule on every AXI channel: a beat transfers on a rising clk edge where valid
// and ready are both 1; the source holds valid and payload stable until that edge.
interface sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

interface axi_if;
  import axi_pkg::*;
  axi_ar_t ar;
  logic    arvalid;
  logic    arready;
  axi_r_t  r;
  logic    rvalid;
  logic    rready;
  axi_aw_t aw;
  logic    awvalid;
  logic    awready;
  axi_w_t  w;
  logic    wvalid;
  logic    wready;
  axi_b_t  b;
  logic    bvalid;
  logic    bready;

  modport master (output ar, arvalid, input arready, input r, rvalid, output rready,
                  output aw, awvalid, input awready, output w, wvalid, input wready,
                  input b, bvalid, output bready);
  modport slave  (input ar, arvalid, output arready, output r, rvalid, input rready,
                  input aw, awvalid, output awready, input w, wvalid, output wready,
                  output b, bvalid, input bready);
endinterface

// File: rtl/sramlike_axi_bridge_wstrb_gen.sv
// Byte-lane strobe from access size and low address bits; size 3 yields no lanes.
module wstrb_gen (
  input  logic [1:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o
);
  always_comb begin
    strb_o = 4'b0000;
    case (size_i)
      2'd0:    strb_o = 4'b0001 << addr_i;
      2'd1:    strb_o = 4'b0011 << {addr_i[1], 1'b0};
      2'd2:    strb_o = 4'b1111;
      default: strb_o = 4'b0000;
    endcase
  end
endmodule

// File: rtl/sramlike_axi_bridge.sv
// sram-like to single-beat AXI3 bridge, one transaction outstanding.
// Define BRIDGE_WR_EARLY_ACK_EN to acknowledge writes once aw and w have both handshaken.
module sramlike_axi_bridge
  import axi_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] RD_ID = 4'd0,
  parameter logic [AXI_ID_W-1:0] WR_ID = 4'd1
) (
  input  logic          clk,
  input  logic          reset,
  sram_if.slave         sram,
  axi_if.master         axi,
  output bridge_state_t state_o
);

  bridge_state_t state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [3:0]  strb;
  logic        aw_hs, w_hs, aw_complete, w_complete;
  logic        unused_fields;

  wstrb_gen u_wstrb_gen (
    .size_i (size_q),
    .addr_i (addr_q[1:0]),
    .strb_o (strb)
  );

  // A channel counts as complete if it handshook earlier or handshakes this cycle.
  assign aw_hs       = (state_q == ST_WR_REQ) && !aw_done_q && axi.awready;
  assign w_hs        = (state_q == ST_WR_REQ) && !w_done_q && axi.wready;
  assign aw_complete = aw_done_q || aw_hs;
  assign w_complete  = w_done_q || w_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (sram.req) begin
          wr_d    = sram.wr;
          size_d  = sram.size;
          addr_d  = sram.addr;
          wdata_d = sram.wdata;
          state_d = sram.wr ? ST_WR_REQ : ST_RD_AR;
        end
      end
      ST_RD_AR: if (axi.arready) state_d = ST_RD_R;
      ST_RD_R:  if (axi.rvalid) state_d = ST_IDLE;
      ST_WR_REQ: begin
        aw_done_d = aw_complete;
        w_done_d  = w_complete;
        if (aw_complete && w_complete) begin
          state_d   = ST_WR_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_WR_B:  if (axi.bvalid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sram.addr_ok = 1'b0;
    sram.data_ok = 1'b0;
    sram.rdata   = 32'd0;
    axi.arvalid  = 1'b0;
    axi.rready   = 1'b0;
    axi.awvalid  = 1'b0;
    axi.wvalid   = 1'b0;
    axi.bready   = 1'b0;
    case (state_q)
      ST_IDLE:  sram.addr_ok = sram.req;
      ST_RD_AR: axi.arvalid = 1'b1;
      ST_RD_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          sram.data_ok = 1'b1;
          sram.rdata   = axi.r.data;
        end
      end
      ST_WR_REQ: begin
        axi.awvalid = !aw_done_q;
        axi.wvalid  = !w_done_q;
`ifdef BRIDGE_WR_EARLY_ACK_EN
        sram.data_ok = aw_complete && w_complete;
`else
        sram.data_ok = 1'b0;
`endif
      end
      ST_WR_B: begin
        axi.bready = 1'b1;
`ifdef BRIDGE_WR_EARLY_ACK_EN
        sram.data_ok = 1'b0;
`else
        sram.data_ok = axi.bvalid;
`endif
      end
      default: ;
    endcase
  end

  assign axi.ar  = '{RD_ID, addr_q, 4'd0, {1'b0, size_q}, BURST_INCR};
  assign axi.aw  = '{WR_ID, addr_q, 4'd0, {1'b0, size_q}, BURST_INCR};
  assign axi.w   = '{WR_ID, wdata_q, strb, 1'b1};
  assign state_o = state_q;

  // Response ids/codes are deliberately ignored; the latched direction is kept for debug visibility.
  assign unused_fields = ^{axi.r.id, axi.r.resp, axi.r.last, axi.b, wr_q};

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Directed plus randomized bench for sramlike_axi_bridge with a transaction-level reference model.
// Honors BRIDGE_WR_EARLY_ACK_EN when defined for the build.
module tb_sramlike_axi_bridge;
  import axi_pkg::*;

  localparam logic [3:0] RD_ID = 4'd0;
  localparam logic [3:0] WR_ID = 4'd1;
`ifdef BRIDGE_WR_EARLY_ACK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk;
  logic          reset;
  bridge_state_t state;
  int            n_checks;
  int            n_fail;
  logic [31:0]   exp_q[$];

  sram_if sram ();
  axi_if  axi ();

  sramlike_axi_bridge #(.RD_ID(RD_ID), .WR_ID(WR_ID)) dut (
    .clk     (clk),
    .reset   (reset),
    .sram    (sram),
    .axi     (axi),
    .state_o (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "time limit reached");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
    int lane;
    lane = int'(addr % 4);
    case (size)
      2'd0:    return 4'(1 << lane);
      2'd1:    return 4'(3 << ((lane / 2) * 2));
      2'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  // driver tasks: inputs change just after negedge, outputs sampled 1ns later
  task automatic do_read(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                         input int ar_d, input int r_d);
    axi_ar_t exp_ar;
    logic [31:0] exp_data;
    exp_ar = '{RD_ID, addr, 4'd0, {1'b0, size}, 2'b01};
    sram.req = 1'b1; sram.wr = 1'b0; sram.size = size; sram.addr = addr; sram.wdata = $urandom;
    #1 chk("rd_addr_ok", 64'(sram.addr_ok), 64'd1);
    exp_q.push_back(data);
    @(negedge clk);
    sram.addr = ~addr; sram.size = 2'($urandom_range(0, 3));
    for (int i = 0; i <= ar_d; i++) begin
      axi.arready = (i == ar_d);
      #1;
      chk("rd_arvalid", 64'(axi.arvalid), 64'd1);
      chk("rd_ar_fields", 64'(axi.ar), 64'(exp_ar));
      chk("rd_pending_addr_ok", 64'(sram.addr_ok), 64'd0);
      @(negedge clk);
    end
    axi.arready = 1'b0;
    for (int j = 0; j <= r_d; j++) begin
      axi.rvalid = (j == r_d);
      axi.r = '{4'($urandom), (j == r_d) ? data : 32'($urandom), 2'($urandom), 1'b1};
      #1;
      chk("rd_rready", 64'(axi.rready), 64'd1);
      chk("rd_arvalid_low", 64'(axi.arvalid), 64'd0);
      chk("rd_data_ok", 64'(sram.data_ok), 64'(j == r_d));
      chk("rd_bubble_addr_ok", 64'(sram.addr_ok), 64'd0);
      if (sram.data_ok) begin
        exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        chk("rd_rdata", 64'(sram.rdata), 64'(exp_data));
      end
      @(negedge clk);
    end
    axi.rvalid = 1'b0; sram.req = 1'b0;
    #1;
    chk("rd_back_idle", 64'(state), 64'(ST_IDLE));
    chk("rd_data_ok_low", 64'(sram.data_ok), 64'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                          input int aw_d, input int w_d, input int b_d);
    axi_aw_t exp_aw;
    axi_w_t  exp_w;
    int      last;
    exp_aw = '{WR_ID, addr, 4'd0, {1'b0, size}, 2'b01};
    exp_w  = '{WR_ID, data, model_strb(size, addr), 1'b1};
    last   = (aw_d > w_d) ? aw_d : w_d;
    sram.req = 1'b1; sram.wr = 1'b1; sram.size = size; sram.addr = addr; sram.wdata = data;
    #1 chk("wr_addr_ok", 64'(sram.addr_ok), 64'd1);
    @(negedge clk);
    sram.req = 1'b0; sram.wdata = ~data; sram.addr = ~addr;
    for (int c = 0; c <= last; c++) begin
      axi.awready = (c == aw_d);
      axi.wready  = (c == w_d);
      #1;
      chk("wr_state_req", 64'(state), 64'(ST_WR_REQ));
      chk("wr_awvalid", 64'(axi.awvalid), 64'(c <= aw_d));
      chk("wr_wvalid", 64'(axi.wvalid), 64'(c <= w_d));
      if (c <= aw_d) chk("wr_aw_fields", 64'(axi.aw), 64'(exp_aw));
      if (c <= w_d) chk("wr_w_fields", 64'(axi.w), 64'(exp_w));
      chk("wr_early_data_ok", 64'(sram.data_ok), 64'(EARLY && (c == last)));
      @(negedge clk);
    end
    axi.awready = 1'b0; axi.wready = 1'b0;
    sram.req = 1'b1; sram.wr = 1'b0;
    for (int k = 0; k <= b_d; k++) begin
      axi.bvalid = (k == b_d);
      axi.b = '{4'($urandom), 2'($urandom)};
      #1;
      chk("wr_state_b", 64'(state), 64'(ST_WR_B));
      chk("wr_bready", 64'(axi.bready), 64'd1);
      chk("wr_valids_low", 64'({axi.awvalid, axi.wvalid}), 64'd0);
      chk("wr_b_addr_ok", 64'(sram.addr_ok), 64'd0);
      chk("wr_b_data_ok", 64'(sram.data_ok), 64'(!EARLY && (k == b_d)));
      @(negedge clk);
    end
    axi.bvalid = 1'b0; sram.req = 1'b0;
    #1;
    chk("wr_back_idle", 64'(state), 64'(ST_IDLE));
    chk("wr_data_ok_low", 64'(sram.data_ok), 64'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1;
    sram.req = 1'b0; sram.wr = 1'b0; sram.size = 2'd0; sram.addr = 32'd0; sram.wdata = 32'd0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.r = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 64'(state), 64'(ST_IDLE));
    chk("reset_valids", 64'({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}), 64'd0);
    chk("reset_sram_outs", 64'({sram.addr_ok, sram.data_ok, sram.rdata}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("idle_no_req_addr_ok", 64'(sram.addr_ok), 64'd0);
    @(negedge clk);

    // minimum-latency word read
    do_read(32'h1FC0_0004, 2'd2, 32'hDEAD_BEEF, 0, 0);
    @(negedge clk);
    // byte write on the top lane
    do_write(32'h8000_0003, 2'd0, 32'hAB00_0000, 0, 0, 0);
    @(negedge clk);
    // aw accepted three cycles before w
    do_write(32'h0000_1002, 2'd1, 32'h1234_0000, 0, 3, 1);
    @(negedge clk);
    do_write(32'h0000_2000, 2'd2, 32'hCAFE_F00D, 2, 0, 4);
    @(negedge clk);
    // arready stalled five cycles with a second request pending
    do_read(32'h0000_3001, 2'd0, 32'h5555_AAAA, 5, 2);
    @(negedge clk);
    do_write(32'h0000_4001, 2'd3, 32'hFFFF_FFFF, 1, 1, 0);
    @(negedge clk);

    // reset while waiting in RD_R
    sram.req = 1'b1; sram.wr = 1'b0; sram.size = 2'd2; sram.addr = 32'h0000_5000;
    @(negedge clk);
    sram.req = 1'b0; axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0; reset = 1'b1;
    #1 chk("rdr_rready_before_reset", 64'(axi.rready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rdr_reset_idle", 64'(state), 64'(ST_IDLE));
    chk("rdr_reset_rready", 64'(axi.rready), 64'd0);
    chk("rdr_reset_arvalid", 64'(axi.arvalid), 64'd0);
    do_read(32'h0000_6008, 2'd1, 32'h0BAD_CAFE, 0, 1);
    @(negedge clk);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read($urandom, 2'($urandom_range(0, 3)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
      @(negedge clk);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sramlike_axi_bridge.md
Name: sramlike_axi_bridge

Overview:
Downstream of the per-port request handshake FSM. Converts one sram-like request (req/addr_ok/data_ok) into single-beat AXI3 read or write transactions. One outstanding transaction at a time. Instantiated once per port (inst, data) ahead of the AXI crossbar.

Parameters:
RD_ID, 0, AXI ID driven on ar.id.
WR_ID, 1, AXI ID driven on aw.id and w.id.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  1  sram-like request, held until addr_ok
wr  in  1  1 = write, 0 = read
size  in  2  0 = byte, 1 = half, 2 = word
addr  in  32  byte address
wdata  in  32  write data, lane-aligned by the requester
addr_ok  out  1  request accepted this cycle
data_ok  out  1  transaction complete this cycle
rdata  out  32  read data, valid only with data_ok on a read
ar  out  axi_ar_t  {id, addr, len, size, burst}
arvalid  out  1
arready  in  1
r  in  axi_r_t  {id, data, resp, last}
rvalid  in  1
rready  out  1
aw  out  axi_aw_t  {id, addr, len, size, burst}
awvalid  out  1
awready  in  1
w  out  axi_w_t  {id, data, strb, last}
wvalid  out  1
wready  in  1
b  in  axi_b_t  {id, resp}
bvalid  in  1
bready  out  1

Behaviour:
- States: IDLE, RD_AR, RD_R, WR_REQ, WR_B. Reset → IDLE. All valids, addr_ok, data_ok, rready and bready are 0 at reset; rdata = 0.
- IDLE: addr_ok = req (combinational). On req: latch wr, size, addr and wdata. Go to RD_AR if !wr, else WR_REQ. No other state asserts addr_ok.
- RD_AR: arvalid = 1, stable until arready. On arready → RD_R.
- RD_R: rready = 1. On rvalid: data_ok = 1, rdata = r.data (passthrough, same cycle) → IDLE.
- WR_REQ: awvalid and wvalid asserted together. Per-channel done flags aw_done and w_done. Each valid drops the cycle after its own handshake. When both handshakes are complete (same or different cycles) → WR_B, clear the flags.
- WR_B: bready = 1. On bvalid: data_ok = 1 → IDLE.
- Minimum read latency: addr_ok in cycle 0, arvalid in cycle 1, data_ok in cycle 2 (arready and rvalid both zero-wait).
- Field encoding: len = 0, burst = INCR (2'b01), last = 1, ar.size/aw.size = {1'b0, size}, addr passed unmodified.
- wstrb: size 0 → 4'b0001 << addr[1:0]; size 1 → 4'b0011 << {addr[1], 1'b0}; size 2 → 4'b1111; size 3 → 4'b0000, with no other special handling.
- resp and id on r/b are ignored; errors are not reported.
- A new request in the cycle of data_ok is not accepted; addr_ok is earliest on the next cycle (back-to-back requests have a 1-cycle bubble).
- Reset mid-transaction returns to IDLE immediately and drops all valids. Outstanding AXI responses are the interconnect's concern.

Optional Feature:
BRIDGE_WR_EARLY_ACK_EN
- Defined: data_ok pulses in the cycle WR_REQ completes (both aw and w handshaken). The FSM still waits in WR_B for bvalid, and addr_ok stays 0 until WR_B exits.
- Undefined: data_ok for writes only on bvalid, as described above.

Decomposition:
- Package axi_pkg holds:
  - axi_ar_t, axi_aw_t, axi_r_t, axi_w_t, axi_b_t;
  - BURST_INCR;
  - bridge_state_t enum.
- Sub-module wstrb_gen (combinational: size and addr[1:0] → strb).
- FSM and latches stay in the top module.

Test Plan:
- Read word addr 0x1FC0_0004, arready = 1, rvalid next cycle with data 0xDEAD_BEEF → ar.addr = 0x1FC0_0004, size = 2, data_ok and rdata = 0xDEAD_BEEF 2 cycles after addr_ok.
- Byte write addr 0x8000_0003, wdata 0xAB00_0000 → w.strb = 4'b1000, aw.size = 0, data_ok on the bvalid cycle.
- Write with awready 3 cycles before wready → awvalid drops after its handshake, wvalid held until wready, single transition to WR_B.
- arready held 0 for 5 cycles → arvalid and ar fields stable all 5 cycles, addr_ok stays 0 for a second pending req.
- Reset asserted in RD_R → next cycle IDLE, rready = 0, a new req gets addr_ok.
- With BRIDGE_WR_EARLY_ACK_EN, bvalid delayed 4 cycles → data_ok when aw/w complete, addr_ok withheld until bvalid.
